// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, Nk/Nr lookup,
// round-constant start value, xtime and the round-key width.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  localparam int         RK_W      = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Key length in 32-bit words; the reserved encoding falls back to AES-128.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    logic [3:0] nk;
    case (kl)
      KEY_LEN_128: nk = 4'd4;
      KEY_LEN_192: nk = 4'd6;
      KEY_LEN_256: nk = 4'd8;
      default:     nk = 4'd4;
    endcase
    return nk;
  endfunction

  // Number of rounds; the reserved encoding falls back to AES-128.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    logic [3:0] nr;
    case (kl)
      KEY_LEN_128: nr = 4'd10;
      KEY_LEN_192: nr = 4'd12;
      KEY_LEN_256: nr = 4'd14;
      default:     nr = 4'd10;
    endcase
    return nr;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box as a combinational 256-entry lookup.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte a lives at bit offset 8*(255-a); ~a gives 255-a without arithmetic.
  always_comb begin
    y = SBOX_TABLE[{~a, 3'b000} +: 8];
  end

endmodule

// File: rtl/sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  sbox u_sbox3 (.a(din[31:24]), .y(dout[31:24]));
  sbox u_sbox2 (.a(din[23:16]), .y(dout[23:16]));
  sbox u_sbox1 (.a(din[15:8]),  .y(dout[15:8]));
  sbox u_sbox0 (.a(din[7:0]),   .y(dout[7:0]));

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: one word per clock, four words per
// round key, round keys handed out over a valid/ready interface.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      key_len,
  input  logic [255:0]    key,
  output logic [RK_W-1:0] rk,
  output logic [3:0]      rk_idx,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic            busy,
  output logic            done
);

  state_t        state_r, state_s;
  logic [255:0]  key_r;
  logic [3:0]    nk_r;
  logic [5:0]    last_r;      // index of the final schedule word, 4*Nr+3
  logic [5:0]    i_r;         // word being generated
  logic [2:0]    mod_r;       // i mod Nk, wrapping counter
  logic [3:0]    rnd_r;       // round keys transferred so far
  logic [7:0]    rcon_r;
  logic [31:0]   win_r [8];   // win_r[0] = w[i-1]
  logic [31:0]   col_r [4];
  logic [2:0]    col_cnt_r;

  logic          start_s, xfer_s, gen_en_s, final_s, key_phase_s;
  logic [31:0]   win_far_s, sw_in_s, sw_out_s, t_s, word_s;

  assign start_s     = (state_r == ST_IDLE) && start;
  assign xfer_s      = (col_cnt_r == 3'd4) && (!rk_valid || rk_ready);
  assign gen_en_s    = (state_r == ST_GEN) && ((col_cnt_r != 3'd4) || xfer_s);
  assign final_s     = (state_r == ST_FLUSH) && (col_cnt_r == 3'd0) && rk_valid && rk_ready;
  assign key_phase_s = (i_r < {2'b00, nk_r});

  sub_word u_sub_word (.din(sw_in_s), .dout(sw_out_s));

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_s = ST_GEN; else state_s = ST_IDLE;
      ST_GEN:   if (gen_en_s && (i_r == last_r)) state_s = ST_FLUSH; else state_s = ST_GEN;
      ST_FLUSH: if (final_s) state_s = ST_IDLE; else state_s = ST_FLUSH;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Schedule-word datapath: pick w[i-Nk], build t, form the new word.
  always_comb begin
    case (nk_r)
      4'd4:    win_far_s = win_r[3];
      4'd6:    win_far_s = win_r[5];
      default: win_far_s = win_r[7];
    endcase
    if (mod_r == 3'd0) begin
      sw_in_s = {win_r[0][23:0], win_r[0][31:24]};
    end else begin
      sw_in_s = win_r[0];
    end
    if (mod_r == 3'd0) begin
      t_s = sw_out_s ^ {rcon_r, 24'h000000};
    end else if ((nk_r == 4'd8) && (mod_r == 3'd4)) begin
      t_s = sw_out_s;
    end else begin
      t_s = win_r[0];
    end
    if (key_phase_s) begin
      word_s = key_r[{~i_r[2:0], 5'b00000} +: 32];
    end else begin
      word_s = win_far_s ^ t_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Latch key and key-size parameters when an expansion is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r  <= 256'h0;
      nk_r   <= 4'd4;
      last_r <= 6'd0;
    end else if (start_s) begin
      key_r  <= key;
      nk_r   <= nk_of(key_len);
      last_r <= {nr_of(key_len), 2'b11};
    end
  end

  // Word counter, i mod Nk, Rcon and window; all hold while generation stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r    <= 6'd0;
      mod_r  <= 3'd0;
      rcon_r <= RCON_INIT;
      for (int k = 0; k < 8; k++) win_r[k] <= 32'h0;
    end else if (start_s) begin
      i_r    <= 6'd0;
      mod_r  <= 3'd0;
      rcon_r <= RCON_INIT;
    end else if (gen_en_s) begin
      i_r <= i_r + 6'd1;
      if ({1'b0, mod_r} == (nk_r - 4'd1)) mod_r <= 3'd0;
      else                                mod_r <= mod_r + 3'd1;
      if (!key_phase_s && (mod_r == 3'd0)) rcon_r <= xtime(rcon_r);
      win_r[0] <= word_s;
      for (int k = 1; k < 8; k++) win_r[k] <= win_r[k-1];
    end
  end

  // Collect buffer: gather four words, empty it on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r <= 3'd0;
      for (int k = 0; k < 4; k++) col_r[k] <= 32'h0;
    end else if (start_s) begin
      col_cnt_r <= 3'd0;
    end else begin
      case ({xfer_s, gen_en_s})
        2'b11: begin
          col_r[0]  <= word_s;
          col_cnt_r <= 3'd1;
        end
        2'b10: col_cnt_r <= 3'd0;
        2'b01: begin
          col_r[col_cnt_r[1:0]] <= word_s;
          col_cnt_r             <= col_cnt_r + 3'd1;
        end
        default: col_cnt_r <= col_cnt_r;
      endcase
    end
  end

  // Round-key output register and valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk       <= '0;
      rk_idx   <= 4'd0;
      rk_valid <= 1'b0;
      rnd_r    <= 4'd0;
    end else if (start_s) begin
      rnd_r <= 4'd0;
    end else if (xfer_s) begin
      rk       <= {col_r[0], col_r[1], col_r[2], col_r[3]};
      rk_idx   <= rnd_r;
      rk_valid <= 1'b1;
      rnd_r    <= rnd_r + 4'd1;
    end else if (rk_valid && rk_ready) begin
      rk_valid <= 1'b0;
    end
  end

  // Status: busy spans the whole expansion, done pulses after the last accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= final_s;
      if (start_s)      busy <= 1'b1;
      else if (final_s) busy <= 1'b0;
    end
  end

endmodule
